// File: rtl/vec_sum_acc_if.sv
// rtl/vec_sum_acc_if.sv - beat input and frame result bus for vec_sum_acc
// Ports (signals):
//   data_i  : VECTOR_LEN packed signed BW_I elements, element k at [(k+1)*BW_I-1 : k*BW_I]
//   valid_i : input beat valid
//   last_i  : final beat of the current frame
//   ready_o : block can accept a beat this cycle
//   data_o  : signed saturated frame result
//   valid_o : data_o holds an unconsumed result
//   sat_o   : data_o was clipped, qualified by valid_o
//   ready_i : downstream accepts data_o
// Modports: slave = block side, master = producer/consumer side.
interface vec_sum_acc_if #(
  parameter int BW_I       = 16,
  parameter int VECTOR_LEN = 13,
  parameter int BW_O       = 16
);
  logic [VECTOR_LEN*BW_I-1:0] data_i;
  logic                       valid_i;
  logic                       last_i;
  logic                       ready_o;
  logic signed [BW_O-1:0]     data_o;
  logic                       valid_o;
  logic                       sat_o;
  logic                       ready_i;

  modport slave (
    input  data_i, valid_i, last_i, ready_i,
    output ready_o, data_o, valid_o, sat_o
  );

  modport master (
    output data_i, valid_i, last_i, ready_i,
    input  ready_o, data_o, valid_o, sat_o
  );
endinterface

// File: rtl/vec_sum_acc.sv
// rtl/vec_sum_acc.sv - per-beat adder tree, frame accumulator, saturated result stage
// Ports:
//   clk_i : clock, all logic on rising edge
//   rst_i : synchronous active-high reset
//   bus   : vec_sum_acc_if.slave (beat input stream and frame result output)
module vec_sum_acc #(
  parameter int BW_I       = 16,
  parameter int VECTOR_LEN = 13,
  parameter int BW_ACC     = 32,
  parameter int BW_O       = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  vec_sum_acc_if.slave bus
);

  localparam int LEVELS = $clog2(VECTOR_LEN);
  localparam int NPAD   = 1 << LEVELS;

  localparam logic signed [BW_ACC-1:0] SAT_MAX =
    {{(BW_ACC-BW_O+1){1'b0}}, {(BW_O-1){1'b1}}};
  localparam logic signed [BW_ACC-1:0] SAT_MIN =
    {{(BW_ACC-BW_O+1){1'b1}}, {(BW_O-1){1'b0}}};

  typedef enum logic {ACCUM, FULL} state_t;

  state_t                   state;
  logic signed [BW_ACC-1:0] acc;
  logic signed [BW_O-1:0]   data_q;
  logic                     sat_q;

  logic signed [BW_ACC-1:0] node [2*NPAD-1];
  logic signed [BW_I-1:0]   elem;
  logic signed [BW_ACC-1:0] beat_sum;
  logic signed [BW_ACC-1:0] total;
  logic signed [BW_O-1:0]   sat_val;
  logic                     clipped;
  logic                     beat_acc;
  logic                     consume;

  // Heap-ordered adder tree: leaves at NPAD-1.., padded with zeros past
  // VECTOR_LEN; node i sums children 2i+1 and 2i+2, root at node 0.
  always_comb begin
    node = '{default: '0};
    elem = '0;
    for (int k = 0; k < NPAD; k++) begin
      if (k < VECTOR_LEN) begin
        elem = bus.data_i[k*BW_I +: BW_I];
        node[NPAD-1+k] = {{(BW_ACC-BW_I){elem[BW_I-1]}}, elem};
      end
    end
    for (int i = NPAD - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    beat_sum = node[0];
  end

  // Accumulator wraps silently; only the conversion to BW_O saturates.
  always_comb begin
    total   = acc + beat_sum;
    sat_val = total[BW_O-1:0];
    clipped = 1'b0;
    if (total > SAT_MAX) begin
      sat_val = SAT_MAX[BW_O-1:0];
      clipped = 1'b1;
    end else if (total < SAT_MIN) begin
      sat_val = SAT_MIN[BW_O-1:0];
      clipped = 1'b1;
    end
  end

  // Ready depends only on the output register and ready_i, never valid_i.
  assign bus.ready_o = (state != FULL) | bus.ready_i;
  assign beat_acc    = bus.valid_i & bus.ready_o;
  assign consume     = (state == FULL) & bus.ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ACCUM;
      acc    <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (consume) begin
        state <= ACCUM;
      end
      // A last beat accepted in the consume cycle overrides the return to
      // ACCUM, giving back-to-back single-beat frames without bubbles.
      if (beat_acc) begin
        if (bus.last_i) begin
          acc    <= '0;
          data_q <= sat_val;
          sat_q  <= clipped;
          state  <= FULL;
        end else begin
          acc <= total;
        end
      end
    end
  end

  assign bus.data_o  = data_q;
  assign bus.sat_o   = sat_q;
  assign bus.valid_o = (state == FULL);

endmodule
